scoreboard_ctrl: RTL and testbench

//  Game scoreboard for the Starflux board top. Holds the current score as an N-digit BCD counter,
//  the all-time high score, and player health, with an IDLE/PLAY/OVER game-state FSM.

---
 rtl/scoreboard_pkg.sv | 42 ++++
 rtl/scoreboard_ctrl_seg7_decode.sv | 30 +++
 rtl/scoreboard_ctrl.sv | 128 ++++++++++++
 tb/tb_scoreboard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types, glyphs and helpers for the scoreboard
package scoreboard_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Returns {carry_out, bcd_sum} for one decimal digit
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s > 5'd9) bcd_digit_add = {1'b1, s[3:0] + 4'd6};
    else          bcd_digit_add = s;
  endfunction

  function automatic logic led_on(input logic [1:0] phase, input int idx);
    case (phase)
      2'd0:    led_on = (idx % 2) == 1;
      2'd1:    led_on = (idx % 4) == 1;
      2'd2:    led_on = (idx % 8) == 1;
      default: led_on = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scoreboard_ctrl_seg7_decode.sv
// rtl/scoreboard_ctrl_seg7_decode.sv - hex nibble to active-low 7-segment glyph
module seg7_decode
  import scoreboard_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - BCD score/high-score/health scoreboard with game-over LED animation
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int SCORE_DIGITS = 4,
  parameter int HEALTH_MAX   = 15,
  parameter int ANIM_DIV     = 12_500_000,
  parameter int LEDR_W       = 18,
  parameter int LEDG_W       = 9
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      game_start,
  input  logic                      score_inc,
  input  logic [3:0]                score_amt,
  input  logic                      hit,
  input  logic                      heal,
  output logic [7*SCORE_DIGITS-1:0] hex_score,
  output logic [7*SCORE_DIGITS-1:0] hex_high,
  output logic [6:0]                hex_health,
  output logic [LEDR_W-1:0]         ledr,
  output logic [LEDG_W-1:0]         ledg,
  output logic                      game_over,
  output logic                      new_record
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam int CW = $clog2(ANIM_DIV);
  localparam logic [SW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};
  localparam logic [3:0]    HMAX      = 4'(HEALTH_MAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(ANIM_DIV - 1);

  state_t        state;
  logic [SW-1:0] score, high, inc_score, next_score;
  logic [3:0]    health, next_health, amt;
  logic [CW-1:0] anim_cnt;
  logic [1:0]    phase;

  // Ripple the clamped amount through all digits; a carry out of the top saturates
  always_comb begin
    logic       carry;
    logic [4:0] r;
    amt       = (score_amt > 4'd9) ? 4'd9 : score_amt;
    carry     = 1'b0;
    r         = '0;
    inc_score = '0;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      r = bcd_digit_add(score[4*d +: 4], (d == 0) ? amt : 4'd0, carry);
      inc_score[4*d +: 4] = r[3:0];
      carry = r[4];
    end
    if (carry) inc_score = ALL_NINES;
    next_score = score_inc ? inc_score : score;
  end

  always_comb begin
    next_health = health;
    if (hit && !heal)                         next_health = health - 4'd1;
    else if (heal && !hit && health < HMAX)   next_health = health + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      score      <= '0;
      high       <= '0;
      health     <= HMAX;
      game_over  <= 1'b0;
      new_record <= 1'b0;
      anim_cnt   <= '0;
      phase      <= '0;
    end else if (game_start) begin
      state      <= PLAY;
      score      <= '0;
      health     <= HMAX;
      game_over  <= 1'b0;
      new_record <= 1'b0;
      anim_cnt   <= '0;
      phase      <= '0;
    end else begin
      case (state)
        PLAY: begin
          score  <= next_score;
          health <= next_health;
          if (next_health == 4'd0) begin
            state     <= OVER;
            game_over <= 1'b1;
            anim_cnt  <= '0;
            phase     <= '0;
            if (next_score > high) begin
              high       <= next_score;
              new_record <= 1'b1;
            end else begin
              new_record <= 1'b0;
            end
          end
        end
        OVER: begin
          if (anim_cnt == CNT_LAST) begin
            anim_cnt <= '0;
            phase    <= phase + 2'd1;
          end else begin
            anim_cnt <= anim_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pure decode of registered state/phase, so the LEDs carry no input-to-output path
  always_comb begin
    ledr = '0;
    ledg = '0;
    if (state == OVER) begin
      for (int i = 0; i < LEDR_W; i++) ledr[i] = led_on(phase, i);
      for (int i = 0; i < LEDG_W; i++) ledg[i] = led_on(phase, i);
    end
  end

  for (genvar d = 0; d < SCORE_DIGITS; d++) begin : g_digits
    seg7_decode u_score (.value(score[4*d +: 4]), .seg(hex_score[7*d +: 7]));
    seg7_decode u_high  (.value(high[4*d +: 4]),  .seg(hex_high[7*d +: 7]));
  end

  seg7_decode u_health (.value(health), .seg(hex_health));

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb/tb_scoreboard_ctrl.sv - self-checking bench for scoreboard_ctrl against a decimal model
module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        game_start = 1'b0, score_inc = 1'b0, hit = 1'b0, heal = 1'b0;
  logic [3:0]  score_amt = 4'd0;
  logic [27:0] hex_score, hex_high;
  logic [6:0]  hex_health;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic        game_over, new_record;

  int total = 0;
  int bad = 0;
  int m_state, m_score, m_high, m_health, m_newrec, m_anim;

  scoreboard_ctrl #(.SCORE_DIGITS(4), .HEALTH_MAX(15), .ANIM_DIV(4), .LEDR_W(18), .LEDG_W(9)) dut (
    .clk(clk), .resetn(resetn), .game_start(game_start), .score_inc(score_inc),
    .score_amt(score_amt), .hit(hit), .heal(heal), .hex_score(hex_score), .hex_high(hex_high),
    .hex_health(hex_health), .ledr(ledr), .ledg(ledg), .game_over(game_over),
    .new_record(new_record)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: glyph = 7'h40;  1: glyph = 7'h79;  2: glyph = 7'h24;  3: glyph = 7'h30;
      4: glyph = 7'h19;  5: glyph = 7'h12;  6: glyph = 7'h02;  7: glyph = 7'h78;
      8: glyph = 7'h00;  9: glyph = 7'h10;  10: glyph = 7'h08; 11: glyph = 7'h03;
      12: glyph = 7'h46; 13: glyph = 7'h21; 14: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input int v);
    int p;
    p = 1;
    exp_hex = '0;
    for (int d = 0; d < 4; d++) begin
      exp_hex[7*d +: 7] = glyph((v / p) % 10);
      p = p * 10;
    end
  endfunction

  // Phase k lights LEDs whose index is 1 modulo 2^(k+1); phase 3 is dark
  function automatic logic [17:0] exp_led(input int w);
    int ph;
    exp_led = '0;
    if (m_state == 2) begin
      ph = (m_anim / 4) % 4;
      for (int i = 0; i < w; i++)
        if (ph < 3 && (i % (2 << ph)) == 1) exp_led[i] = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_health = 15; m_newrec = 0; m_anim = 0;
  endtask

  task automatic step(input logic gs, input logic si, input logic [3:0] amt,
                      input logic h, input logic hl);
    int a;
    game_start = gs; score_inc = si; score_amt = amt; hit = h; heal = hl;
    @(posedge clk);
    if (gs) begin
      m_state = 1; m_score = 0; m_health = 15; m_newrec = 0; m_anim = 0;
    end else if (m_state == 1) begin
      a = (amt > 9) ? 9 : int'(amt);
      if (si) m_score = (m_score + a > 9999) ? 9999 : m_score + a;
      if (h && !hl) m_health = m_health - 1;
      else if (hl && !h && m_health < 15) m_health = m_health + 1;
      if (m_health == 0) begin
        m_state = 2; m_anim = 0;
        if (m_score > m_high) begin m_high = m_score; m_newrec = 1; end
        else m_newrec = 0;
      end
    end else if (m_state == 2) begin
      m_anim = m_anim + 1;
    end
    @(negedge clk);
    game_start = 0; score_inc = 0; score_amt = 0; hit = 0; heal = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (hex_score !== exp_hex(0)) begin bad++; $display("FAIL reset_score got=%h want=%h", hex_score, exp_hex(0)); end
    total++; if (hex_high !== exp_hex(0)) begin bad++; $display("FAIL reset_high got=%h want=%h", hex_high, exp_hex(0)); end
    total++; if (hex_health !== 7'h0E) begin bad++; $display("FAIL reset_health got=%h want=0e", hex_health); end
    total++; if ({game_over, new_record} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {game_over, new_record}); end
    total++; if (ledr !== 18'd0 || ledg !== 9'd0) begin bad++; $display("FAIL reset_leds got=%h/%h want=0/0", ledr, ledg); end
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignored();
    step(0, 1, 4'd5, 1, 0);
    step(0, 1, 4'd3, 0, 1);
    total++; if (hex_score !== exp_hex(0)) begin bad++; $display("FAIL idle_score got=%h want=%h", hex_score, exp_hex(0)); end
    total++; if (hex_health !== glyph(15)) begin bad++; $display("FAIL idle_health got=%h want=%h", hex_health, glyph(15)); end
  endtask

  task automatic test_start();
    step(1, 0, 4'd0, 0, 0);
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL start_over got=%b want=0", game_over); end
    total++; if (hex_health !== 7'h0E) begin bad++; $display("FAIL start_health got=%h want=0e", hex_health); end
    total++; if (hex_score !== exp_hex(0)) begin bad++; $display("FAIL start_score got=%h want=%h", hex_score, exp_hex(0)); end
  endtask

  task automatic test_score();
    for (int i = 0; i < 25; i++) step(0, 1, 4'd4, 0, 0);
    total++; if (hex_score !== exp_hex(100)) begin bad++; $display("FAIL score_100 got=%h want=%h", hex_score, exp_hex(100)); end
    for (int i = 0; i < 1099; i++) step(0, 1, 4'd9, 0, 0);
    step(0, 1, 4'd4, 0, 0);
    total++; if (hex_score !== exp_hex(9995)) begin bad++; $display("FAIL score_9995 got=%h want=%h", hex_score, exp_hex(9995)); end
    step(0, 1, 4'd9, 0, 0);
    total++; if (hex_score !== exp_hex(9999)) begin bad++; $display("FAIL score_sat got=%h want=%h", hex_score, exp_hex(9999)); end
    step(0, 1, 4'd15, 0, 0);
    total++; if (hex_score !== exp_hex(9999)) begin bad++; $display("FAIL score_sat_hold got=%h want=%h", hex_score, exp_hex(9999)); end
  endtask

  task automatic test_death();
    step(0, 0, 4'd0, 1, 1);
    total++; if (hex_health !== glyph(15)) begin bad++; $display("FAIL cancel_full got=%h want=%h", hex_health, glyph(15)); end
    step(0, 0, 4'd0, 1, 0);
    step(0, 0, 4'd0, 1, 1);
    total++; if (hex_health !== glyph(14)) begin bad++; $display("FAIL cancel_14 got=%h want=%h", hex_health, glyph(14)); end
    step(0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 4'd0, 1, 0);
      if (i == 13) begin
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL over_early got=%b want=0", game_over); end
      end
    end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_15th got=%b want=1", game_over); end
    total++; if (new_record !== 1'b1) begin bad++; $display("FAIL record_set got=%b want=1", new_record); end
    total++; if (hex_high !== exp_hex(9999)) begin bad++; $display("FAIL high_set got=%h want=%h", hex_high, exp_hex(9999)); end
    total++; if (hex_health !== glyph(0)) begin bad++; $display("FAIL health_zero got=%h want=%h", hex_health, glyph(0)); end
    step(0, 1, 4'd3, 0, 1);
    total++; if (hex_score !== exp_hex(9999) || hex_health !== glyph(0)) begin bad++; $display("FAIL over_ignored got=%h/%h want=%h/%h", hex_score, hex_health, exp_hex(9999), glyph(0)); end
  endtask

  task automatic test_second_game();
    step(1, 1, 4'd5, 1, 0);
    total++; if ({game_over, new_record} !== 2'b00) begin bad++; $display("FAIL restart_flags got=%b want=00", {game_over, new_record}); end
    total++; if (hex_score !== exp_hex(0) || hex_high !== exp_hex(9999)) begin bad++; $display("FAIL restart_vals got=%h/%h want=%h/%h", hex_score, hex_high, exp_hex(0), exp_hex(9999)); end
    step(0, 0, 4'd0, 0, 1);
    total++; if (hex_health !== glyph(15)) begin bad++; $display("FAIL heal_sat got=%h want=%h", hex_health, glyph(15)); end
    for (int i = 0; i < 14; i++) step(0, 0, 4'd0, 1, 0);
    step(0, 1, 4'd7, 1, 0);
    total++; if (hex_score !== exp_hex(7)) begin bad++; $display("FAIL fatal_inc got=%h want=%h", hex_score, exp_hex(7)); end
    total++; if ({game_over, new_record} !== 2'b10) begin bad++; $display("FAIL lower_flags got=%b want=10", {game_over, new_record}); end
    total++; if (hex_high !== exp_hex(9999)) begin bad++; $display("FAIL high_kept got=%h want=%h", hex_high, exp_hex(9999)); end
  endtask

  task automatic test_anim();
    logic [17:0] e;
    for (int i = 0; i < 20; i++) begin
      e = exp_led(18);
      total++; if (ledr !== e) begin bad++; $display("FAIL anim_ledr t=%0d got=%h want=%h", m_anim, ledr, e); end
      e = exp_led(9);
      total++; if (ledg !== e[8:0]) begin bad++; $display("FAIL anim_ledg t=%0d got=%h want=%h", m_anim, ledg, e[8:0]); end
      step(0, 0, 4'd0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 4'd0, 0, 0);
    step(0, 1, 4'd6, 0, 0);
    #2 resetn = 0;
    #1;
    model_reset();
    total++; if (hex_score !== exp_hex(0) || hex_high !== exp_hex(0)) begin bad++; $display("FAIL areset_play got=%h/%h want=%h/%h", hex_score, hex_high, exp_hex(0), exp_hex(0)); end
    @(negedge clk);
    resetn = 1;
    step(1, 0, 4'd0, 0, 0);
    step(0, 1, 4'd8, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 4'd0, 1, 0);
    repeat (5) step(0, 0, 4'd0, 0, 0);
    total++; if (hex_high !== exp_hex(8) || ledr === 18'd0) begin bad++; $display("FAIL pre_areset got=%h/%h want=%h/nonzero", hex_high, ledr, exp_hex(8)); end
    #2 resetn = 0;
    #1;
    model_reset();
    total++; if ({game_over, new_record} !== 2'b00 || ledr !== 18'd0 || ledg !== 9'd0) begin bad++; $display("FAIL areset_anim got=%b/%h/%h want=00/0/0", {game_over, new_record}, ledr, ledg); end
    total++; if (hex_high !== exp_hex(0) || hex_health !== glyph(15)) begin bad++; $display("FAIL areset_vals got=%h/%h want=%h/%h", hex_high, hex_health, exp_hex(0), glyph(15)); end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_random();
    logic [17:0] e;
    step(1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      total++; if (hex_score !== exp_hex(m_score)) begin bad++; $display("FAIL rnd_score i=%0d got=%h want=%h", i, hex_score, exp_hex(m_score)); end
      total++; if (hex_high !== exp_hex(m_high)) begin bad++; $display("FAIL rnd_high i=%0d got=%h want=%h", i, hex_high, exp_hex(m_high)); end
      total++; if (hex_health !== glyph(m_health)) begin bad++; $display("FAIL rnd_health i=%0d got=%h want=%h", i, hex_health, glyph(m_health)); end
      total++; if (game_over !== (m_state == 2)) begin bad++; $display("FAIL rnd_over i=%0d got=%b want=%b", i, game_over, (m_state == 2)); end
      total++; if (new_record !== (m_state == 2 && m_newrec == 1)) begin bad++; $display("FAIL rnd_record i=%0d got=%b want=%b", i, new_record, (m_state == 2 && m_newrec == 1)); end
      e = exp_led(18);
      total++; if (ledr !== e) begin bad++; $display("FAIL rnd_ledr i=%0d got=%h want=%h", i, ledr, e); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_start();
    test_score();
    test_death();
    test_second_game();
    test_anim();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
